// File: rtl/scan_display.sv
// ============================================================================
// scan_display
// ----------------------------------------------------------------------------
// Multiplexed seven-segment display driver. N_DIGITS hex digits, each with
// an enable and a decimal point, share one active-low segment bus. Each
// digit also has its own active-low anode line. The scan rate comes from an
// internal prescaler. All inputs are copied into shadow registers once per
// frame, so a frame never mixes old and new values.
//
// Optional feature: define SCAN_DISPLAY_BLINK_EN to enable per-digit
// blinking. The blink phase toggles every BLINK_FRAMES frames. Without the
// macro the blink port is accepted but ignored.
//
// Parameters:
//   N_DIGITS     number of digits (1..8)
//   SCAN_DIV     clk cycles each digit stays selected (>= 1)
//   BLINK_FRAMES frames per blink half-period (>= 1, blink build only)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   digits       digit i value on [4i+3:4i], digit 0 rightmost
//   enables      per-digit lit enable
//   dps          per-digit decimal point enable
//   blink        per-digit blink request
//   seg          {a,b,c,d,e,f,g}, active-low
//   dp           decimal point, active-low
//   an           anode selects, active-low, at most one low
//   frame_start  one-cycle pulse in the cycle after the shadow registers load
// ============================================================================
module scan_display #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   enables,
    input  logic [N_DIGITS-1:0]   dps,
    input  logic [N_DIGITS-1:0]   blink,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);

    // Hex to {a..g}, active-low.
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    logic [PW-1:0]           r_pcnt;
    logic [IW-1:0]           r_idx;
    logic [4*N_DIGITS-1:0]   r_sh_digits;
    logic [N_DIGITS-1:0]     r_sh_en;
    logic [N_DIGITS-1:0]     r_sh_dp;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [N_DIGITS-1:0]     r_an;
    logic                    r_frame_start;

    logic                    w_tick;
    logic                    w_boundary;
    logic [PW-1:0]           w_pcnt_next;
    logic [IW-1:0]           w_idx_next;
    logic [4*N_DIGITS-1:0]   w_sh_digits_next;
    logic [N_DIGITS-1:0]     w_sh_en_next;
    logic [N_DIGITS-1:0]     w_sh_dp_next;
    logic [3:0]              w_nib [N_DIGITS];
    logic                    w_blank_blink;
    logic                    w_lit;

    assign w_tick      = (r_pcnt == P_LAST);
    assign w_boundary  = w_tick && (r_idx == I_LAST);
    assign w_pcnt_next = w_tick ? '0 : r_pcnt + PW'(1);
    assign w_idx_next  = !w_tick ? r_idx :
                         (r_idx == I_LAST) ? '0 : r_idx + IW'(1);

    assign w_sh_digits_next = w_boundary ? digits  : r_sh_digits;
    assign w_sh_en_next     = w_boundary ? enables : r_sh_en;
    assign w_sh_dp_next     = w_boundary ? dps     : r_sh_dp;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_nib
            assign w_nib[gi] = w_sh_digits_next[4*gi +: 4];
        end
    endgenerate

`ifdef SCAN_DISPLAY_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0]       r_fcnt;
    logic                r_phase;
    logic [N_DIGITS-1:0] r_sh_blink;
    logic                w_fwrap;
    logic                w_phase_next;
    logic [N_DIGITS-1:0] w_sh_blink_next;

    assign w_fwrap         = w_boundary && (r_fcnt == F_LAST);
    assign w_phase_next    = r_phase ^ w_fwrap;
    assign w_sh_blink_next = w_boundary ? blink : r_sh_blink;
    assign w_blank_blink   = w_phase_next && w_sh_blink_next[w_idx_next];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt     <= '0;
            r_phase    <= 1'b0;
            r_sh_blink <= '0;
        end else begin
            if (w_boundary) begin
                r_fcnt <= w_fwrap ? '0 : r_fcnt + FW'(1);
            end
            r_phase    <= w_phase_next;
            r_sh_blink <= w_sh_blink_next;
        end
    end
`else
    logic w_blink_unused;
    localparam int unused_blink_frames = BLINK_FRAMES;
    assign w_blink_unused = ^blink;
    assign w_blank_blink  = 1'b0;
`endif

    // Output registers use the next slot index and the next shadow contents.
    // The pins then show the slot and frame that the counters are entering.
    // As a result, digit 0 of a newly loaded frame appears together with
    // frame_start.
    assign w_lit = w_sh_en_next[w_idx_next] && !w_blank_blink;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt        <= '0;
            r_idx         <= '0;
            r_sh_digits   <= '0;
            r_sh_en       <= '0;
            r_sh_dp       <= '0;
            r_seg         <= 7'h7F;
            r_dp          <= 1'b1;
            r_an          <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_pcnt        <= w_pcnt_next;
            r_idx         <= w_idx_next;
            r_sh_digits   <= w_sh_digits_next;
            r_sh_en       <= w_sh_en_next;
            r_sh_dp       <= w_sh_dp_next;
            r_frame_start <= w_boundary;
            if (w_lit) begin
                r_an  <= ~(N_DIGITS'(1) << w_idx_next);
                r_seg <= hex_decode(w_nib[w_idx_next]);
                r_dp  <= ~w_sh_dp_next[w_idx_next];
            end else begin
                r_an  <= '1;
                r_seg <= 7'h7F;
                r_dp  <= 1'b1;
            end
        end
    end

    assign seg         = r_seg;
    assign dp          = r_dp;
    assign an          = r_an;
    assign frame_start = r_frame_start;

endmodule
